// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: bundle of the serial line, sampler hookup, configuration
// and status signals exchanged with the UART receive controller.
// master drives the line/config side, slave is the controller itself.
interface uart_rx_ctrl_if;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       Sampled_bit;
    logic       dat_samp_en;
    logic [5:0] Edge_count;
    logic [4:0] Bit_count;
    logic       deser_en;
    logic       Data_Valid;
    logic       Par_err;
    logic       Stp_err;
    logic       busy;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP, Sampled_bit,
        input  dat_samp_en, Edge_count, Bit_count, deser_en, Data_Valid,
               Par_err, Stp_err, busy
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP, Sampled_bit,
        output dat_samp_en, Edge_count, Bit_count, deser_en, Data_Valid,
               Par_err, Stp_err, busy
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame controller. Tracks oversample ticks and
// bit position of a frame, enables the sampler, strobes the deserializer
// and reports parity/stop errors and a frame-accepted pulse.
// Optional feature macro: UART_RX_PARITY_EN (parity bit state and Par_err
// checking). Without it PAR_EN/PAR_TYP are ignored and Par_err stays 0.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input logic           CLK,
    input logic           RST,
    uart_rx_ctrl_if.slave bus
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, VALID} state_t;

    state_t     state;
    logic [5:0] pre_l;
    logic [5:0] edge_cnt;
    logic [4:0] bit_cnt;
    logic       samp_en;
    logic       deser;
    logic       dvalid;
    logic       stp_err;
    logic       par_err;
    logic       busy_q;
    logic       last_tick;

    // Bit decisions happen on the final oversample tick of each bit period.
    assign last_tick = (edge_cnt == pre_l - 6'd1);

    // Oversampling ratio is captured at frame start so mid-frame changes are ignored.
    always_ff @(posedge CLK) begin
        if (state == IDLE && !bus.RX_IN) begin
            pre_l <= bus.Prescale;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_en_l;
    logic par_typ_l;
    logic par_acc;

    // Latch parity mode at frame start and fold each decided data bit into the running parity.
    always_ff @(posedge CLK) begin
        if (state == IDLE && !bus.RX_IN) begin
            par_en_l  <= bus.PAR_EN;
            par_typ_l <= bus.PAR_TYP;
            par_acc   <= 1'b0;
        end else if (state == DATA && last_tick) begin
            par_acc <= par_acc ^ bus.Sampled_bit;
        end
    end
`else
    logic unused_par_cfg;
    assign unused_par_cfg = ^{bus.PAR_EN, bus.PAR_TYP};
    assign par_err        = 1'b0;
`endif

    // Frame FSM with tick/bit counters and all status outputs registered.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            edge_cnt <= 6'd0;
            bit_cnt  <= 5'd0;
            samp_en  <= 1'b0;
            deser    <= 1'b0;
            dvalid   <= 1'b0;
            stp_err  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err  <= 1'b0;
`endif
        end else begin
            // Strobe lands in the decision cycle so Bit_count still names the bit being written.
            deser  <= (state == DATA) && (edge_cnt == pre_l - 6'd2);
            dvalid <= 1'b0;

            if (state != IDLE && state != VALID) begin
                if (last_tick) begin
                    edge_cnt <= 6'd0;
                    bit_cnt  <= bit_cnt + 5'd1;
                end else begin
                    edge_cnt <= edge_cnt + 6'd1;
                end
            end

            case (state)
                IDLE: begin
                    edge_cnt <= 6'd0;
                    bit_cnt  <= 5'd0;
                    if (!bus.RX_IN) begin
                        state   <= START;
                        samp_en <= 1'b1;
                        busy_q  <= 1'b1;
                        stp_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        par_err <= 1'b0;
`endif
                    end
                end
                START: begin
                    if (last_tick) begin
                        if (bus.Sampled_bit) begin
                            // Start bit did not hold low: treat as line glitch.
                            state   <= IDLE;
                            samp_en <= 1'b0;
                            busy_q  <= 1'b0;
                            bit_cnt <= 5'd0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (last_tick && bit_cnt == 5'(DATA_WIDTH)) begin
`ifdef UART_RX_PARITY_EN
                        state <= par_en_l ? PARITY : STOP;
`else
                        state <= STOP;
`endif
                    end
                end
                PARITY: begin
                    if (last_tick) begin
`ifdef UART_RX_PARITY_EN
                        par_err <= (bus.Sampled_bit != (par_acc ^ par_typ_l));
`endif
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (last_tick) begin
                        stp_err  <= !bus.Sampled_bit;
                        dvalid   <= !par_err && bus.Sampled_bit;
                        samp_en  <= 1'b0;
                        edge_cnt <= 6'd0;
                        bit_cnt  <= 5'd0;
                        state    <= VALID;
                    end
                end
                VALID: begin
                    state    <= IDLE;
                    busy_q   <= 1'b0;
                    edge_cnt <= 6'd0;
                    bit_cnt  <= 5'd0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.dat_samp_en = samp_en;
    assign bus.Edge_count  = edge_cnt;
    assign bus.Bit_count   = bit_cnt;
    assign bus.deser_en    = deser;
    assign bus.Data_Valid  = dvalid;
    assign bus.Par_err     = par_err;
    assign bus.Stp_err     = stp_err;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl. Stimulus tasks push the
// expected frame outcome; a negedge monitor rebuilds each frame from the
// deserializer strobes and compares it when the controller drops busy.
module tb_uart_rx_ctrl;
    localparam int DW = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_CFG = 1'b1;
`else
    localparam bit PAR_CFG = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] data;
        bit            valid;
        bit            perr;
        bit            serr;
        bit            glitch;
        int            lat;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    bit   abort = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    uart_rx_ctrl_if bus();

    uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            if (abort) begin
                bus.RX_IN       = 1'b1;
                bus.Sampled_bit = 1'b1;
                return;
            end
            bus.RX_IN       = v;
            bus.Sampled_bit = v;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] data, input int p, input bit pen,
                              input bit ptyp, input bit bad_par, input bit stop_val,
                              input bit wiggle, input bit push);
        exp_t e;
        bit   pbit;
        bit   eff_pen;
        bit   stop_seen;
        pbit      = (^data) ^ ptyp ^ bad_par;
        eff_pen   = pen && PAR_CFG;
        stop_seen = (pen && !eff_pen) ? pbit : stop_val;
        e.data    = data;
        e.glitch  = 1'b0;
        e.perr    = eff_pen && bad_par;
        e.serr    = !stop_seen;
        e.valid   = !e.perr && !e.serr;
        e.lat     = p * (DW + 2 + (eff_pen ? 1 : 0));
        if (push) exp_q.push_back(e);
        bus.Prescale = 6'(p);
        bus.PAR_EN   = pen;
        bus.PAR_TYP  = ptyp;
        drive_bit(1'b0, 1);
        if (wiggle) bus.Prescale = (p == 8) ? 6'd32 : 6'd8;
        drive_bit(1'b0, p);
        for (int i = 0; i < DW; i++) drive_bit(data[i], p);
        if (pen) drive_bit(pbit, p);
        drive_bit(stop_val, p);
        drive_bit(1'b1, 1);
        bus.Prescale = 6'(p);
    endtask

    task automatic send_glitch();
        exp_t e;
        e.data   = '0;
        e.glitch = 1'b1;
        e.perr   = 1'b0;
        e.serr   = 1'b0;
        e.valid  = 1'b0;
        e.lat    = 0;
        exp_q.push_back(e);
        bus.Prescale    = 6'd8;
        bus.PAR_EN      = 1'b0;
        bus.Sampled_bit = 1'b1;
        bus.RX_IN       = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
        end
        drive_bit(1'b1, 14);
    endtask

    // Monitor state
    bit            prev_busy = 1'b0;
    int            cyc = 0;
    int            n_deser = 0;
    int            dv_seen = 0;
    int            dv_cyc = -1;
    logic [DW-1:0] acc = '0;
    exp_t          got_e;

    always @(negedge CLK) begin
        if (!RST) begin
            prev_busy = 1'b0;
        end else begin
            if (bus.busy && !prev_busy) begin
                check("flags_clear_at_start", {bus.Par_err, bus.Stp_err}, 2'b00);
                check("samp_en_at_start", bus.dat_samp_en, 1'b1);
                cyc     = 0;
                n_deser = 0;
                dv_seen = 0;
                dv_cyc  = -1;
                acc     = '0;
            end else if (bus.busy) begin
                cyc++;
            end
            if (bus.deser_en) begin
                check("deser_bit_count", bus.Bit_count, n_deser + 1);
                if (n_deser < DW) acc[n_deser] = bus.Sampled_bit;
                n_deser++;
            end
            if (bus.Data_Valid) begin
                dv_seen++;
                dv_cyc = cyc;
                check("valid_counters_clear", {bus.Edge_count, bus.Bit_count}, 0);
            end
            if (prev_busy && !bus.busy) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_frame", 1, 0);
                end else begin
                    got_e = exp_q.pop_front();
                    if (got_e.glitch) begin
                        check("glitch_deser", n_deser, 0);
                        check("glitch_dv", dv_seen, 0);
                        check("glitch_bitcnt", bus.Bit_count, 0);
                    end else begin
                        check("dv_count", dv_seen, got_e.valid ? 1 : 0);
                        check("par_err", bus.Par_err, got_e.perr);
                        check("stp_err", bus.Stp_err, got_e.serr);
                        check("deser_count", n_deser, DW);
                        if (got_e.valid) begin
                            check("data", acc, got_e.data);
                            check("dv_latency", dv_cyc, got_e.lat);
                        end
                    end
                end
            end
            prev_busy = bus.busy;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.RX_IN       = 1'b1;
        bus.Sampled_bit = 1'b1;
        bus.Prescale    = 6'd8;
        bus.PAR_EN      = 1'b0;
        bus.PAR_TYP     = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_edge_count", bus.Edge_count, 0);
        check("rst_bit_count", bus.Bit_count, 0);
        check("rst_samp_en", bus.dat_samp_en, 0);
        check("rst_deser_en", bus.deser_en, 0);
        check("rst_data_valid", bus.Data_Valid, 0);
        check("rst_par_err", bus.Par_err, 0);
        check("rst_stp_err", bus.Stp_err, 0);
        check("rst_busy", bus.busy, 0);
        RST = 1'b1;
        drive_bit(1'b1, 4);

        // 0xA5, Prescale 8, no parity
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        drive_bit(1'b1, 3);
        // 0x0F, Prescale 16, even parity with wrong parity bit
        send_frame(8'h0F, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        drive_bit(1'b1, 3);
        // Prescale 32, stop bit low
        send_frame(8'h3A, 32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1, 3);
        // Prescale 32 with the Prescale input disturbed mid-frame
        send_frame(8'hC3, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        drive_bit(1'b1, 3);
        // Short low pulse on the line
        send_glitch();

        // Reset in the middle of a frame
        fork
            send_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            begin
                bit hit;
                hit = 1'b0;
                for (int k = 0; k < 400 && !hit; k++) begin
                    @(negedge CLK);
                    if (bus.Bit_count == 5'd4) hit = 1'b1;
                end
                check("rst_mid_reached", hit, 1);
                RST   = 1'b0;
                abort = 1'b1;
                #1;
                check("rst_mid_edge_count", bus.Edge_count, 0);
                check("rst_mid_bit_count", bus.Bit_count, 0);
                check("rst_mid_busy", bus.busy, 0);
                check("rst_mid_others",
                      {bus.dat_samp_en, bus.deser_en, bus.Data_Valid, bus.Par_err, bus.Stp_err}, 0);
                repeat (2) @(negedge CLK);
                RST = 1'b1;
            end
        join
        abort = 1'b0;
        drive_bit(1'b1, 4);
        send_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Back-to-back frames, second with correct odd parity
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        drive_bit(1'b1, 4);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge CLK);
        #1;
        check("sb_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 Port CLK  input  1  receiver oversampling clock.
REQ-003 Port RST  input  1  reset; asynchronous, active-low.
REQ-004 Port RX_IN  input  1  serial line, idle high.
REQ-005 Port Prescale  input  6  oversampling ratio; legal values 8, 16, 32.
REQ-006 Port PAR_EN  input  1  parity bit present when 1.
REQ-007 Port PAR_TYP  input  1  0 even, 1 odd.
REQ-008 Port Sampled_bit  input  1  majority-voted bit from the sampler.
REQ-009 Port dat_samp_en  output  1  sampler enable.
REQ-010 Port Edge_count  output  6  oversample tick within the current bit.
REQ-011 Port Bit_count  output  5  bit index: 0 start, 1..DATA_WIDTH data, then parity, then stop.
REQ-012 Port deser_en  output  1  one-cycle deserializer write strobe.
REQ-013 Port Data_Valid  output  1  one-cycle frame-accepted pulse.
REQ-014 Port Par_err  output  1  parity error flag.
REQ-015 Port Stp_err  output  1  stop error flag.
REQ-016 Port busy  output  1  frame in progress.

Function
REQ-017 The FSM SHALL use the states IDLE, START, DATA, PARITY, STOP, and VALID.
REQ-018 IDLE: RX_IN=0 SHALL latch Prescale and PAR_EN/PAR_TYP, clear Par_err/Stp_err, clear Edge_count, and move to START next cycle.
REQ-019 Edge_count SHALL increment each cycle outside IDLE and wrap from latched Prescale-1 to 0, incrementing Bit_count on wrap.
REQ-020 dat_samp_en SHALL be 1 in every state except IDLE and VALID.
REQ-021 Bit decision SHALL occur at Edge_count==Prescale-1 using Sampled_bit.
REQ-022 START: decision 1 (glitch) -> IDLE, no flags, no Data_Valid; decision 0 -> DATA.
REQ-023 DATA: deser_en SHALL pulse at each decision with Bit_count = 1..DATA_WIDTH, and the running parity XOR SHALL update.
REQ-024 After the decision at Bit_count==DATA_WIDTH: -> PARITY if the latched PAR_EN=1, else -> STOP.
REQ-025 PARITY: Par_err SHALL be set when Sampled_bit != (XOR ^ PAR_TYP).
REQ-026 STOP: Sampled_bit=0 SHALL set Stp_err; the next state SHALL be VALID.
REQ-027 VALID (one cycle): Data_Valid=1 iff Par_err=0 and Stp_err=0; Bit_count and Edge_count SHALL clear; -> IDLE.
REQ-028 A frame starting immediately after VALID SHALL be accepted (RX_IN=0 sampled in IDLE the next cycle).
REQ-029 Par_err/Stp_err SHALL hold until the next frame start.
REQ-030 busy SHALL be 1 in START..VALID.
REQ-031 Prescale changes while busy SHALL be ignored until the next frame.

Reset
REQ-032 RST low SHALL force IDLE, and all outputs and counters SHALL be 0, at any time including mid-frame.
REQ-033 After RST deasserts, the first start SHALL be detected on the first cycle with RX_IN=0.

Configuration
REQ-034 Macro UART_RX_PARITY_EN defined: PARITY state and Par_err logic SHALL be present as specified.
REQ-035 Macro UART_RX_PARITY_EN undefined: PAR_EN/PAR_TYP SHALL be ignored, DATA -> STOP always, and Par_err SHALL be tied to 0.

Verification
REQ-036 Prescale=8, PAR_EN=0, byte 0xA5 -> 8 deser_en pulses with Bit_count 1..8, Data_Valid 1 cycle at 80 cycles after the start edge, no flags.
REQ-037 Prescale=16, PAR_EN=1, PAR_TYP=0, 0x0F with parity bit 1 -> Par_err=1, no Data_Valid.
REQ-038 Prescale=32, stop bit sent as 0 -> Stp_err=1, no Data_Valid, and the flag clears at the next start.
REQ-039 RX_IN low for 3 cycles at Prescale=8 -> return to IDLE after the start decision, no deser_en.
REQ-040 RST pulse at Bit_count=4 -> all outputs 0, and the next full frame is received correctly.
REQ-041 Two back-to-back frames 0x55, 0x3C -> two Data_Valid pulses, with no frame lost.
